fir_interp2_folded: RTL

//  2x polyphase interpolating FIR on a folded symmetric prototype. Accepts one sample per

---
 rtl/fir_pkg.sv | 25 ++
 rtl/fir_fold_mac.sv | 38 +++
 rtl/fir_interp2_folded.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared widths, FSM state encoding and halfband coefficient table for the
// folded 2x interpolating FIR.
package fir_pkg;

    localparam int unsigned DefOrder   = 10;
    localparam int unsigned CoeffWidth = 16;
    localparam int unsigned DataWidth  = 16;
    localparam int unsigned FracBits   = 8;
    localparam int unsigned NumCoeffs  = DefOrder / 2 + 1;
    localparam int unsigned AccWidth   = DataWidth + CoeffWidth + 3;

    typedef enum logic [2:0] {
        StIdle,
        StMacE,
        StOutE,
        StMacO,
        StOutO
    } state_e;

    // Unique half of the symmetric prototype, Q8.8; h[k] == h[DefOrder-k].
    localparam logic signed [CoeffWidth-1:0] Coeffs [NumCoeffs] = '{
        16'sd3, 16'sd0, -16'sd25, 16'sd0, 16'sd150, 16'sd256
    };

endpackage

// File: rtl/fir_fold_mac.sv
// Shared pre-add / multiply / accumulate unit. acc_o is the value the
// accumulator takes this cycle, so the final sum is visible on the last tap.
module fir_fold_mac
    import fir_pkg::*;
#(
    parameter int unsigned DataW  = DataWidth,
    parameter int unsigned CoeffW = CoeffWidth,
    parameter int unsigned AccW   = AccWidth
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic signed [DataW-1:0]  a_i,
    input  logic signed [DataW-1:0]  b_i,
    input  logic signed [CoeffW-1:0] coeff_i,
    input  logic                     load_i,
    input  logic                     en_i,
    output logic signed [AccW-1:0]   acc_o
);

    logic signed [DataW:0]        pre_add;
    logic signed [DataW+CoeffW:0] prod;
    logic signed [AccW-1:0]       acc_q;

    always_comb begin
        pre_add = {a_i[DataW-1], a_i} + {b_i[DataW-1], b_i};
        prod    = pre_add * coeff_i;
        acc_o   = load_i ? AccW'(prod) : acc_q + AccW'(prod);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_o;
        end
    end

endmodule

// File: rtl/fir_interp2_folded.sv
// 2x polyphase interpolating FIR on a folded symmetric prototype: one input
// sample in, even-phase then odd-phase sample out, one shared MAC.
module fir_interp2_folded
    import fir_pkg::*;
#(
    parameter int unsigned ORDER              = DefOrder,
    parameter int unsigned COEFFICIENTS_WIDTH = CoeffWidth,
    parameter int unsigned DATA_WIDTH         = DataWidth
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_phase
);

    localparam int D    = (ORDER + 2) / 2;
    localparam int Half = D / 2;
    localparam int TapW = (Half > 1) ? $clog2(Half) : 1;
    localparam int AccW = DATA_WIDTH + COEFFICIENTS_WIDTH + 3;

    localparam logic signed [AccW-1:0] SatMax = AccW'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [AccW-1:0] SatMin = AccW'(-(1 << (DATA_WIDTH - 1)));

    state_e                         state_q, state_d;
    logic [TapW-1:0]                tap_q, tap_d;
    logic signed [DATA_WIDTH-1:0]   x_q [D];
    logic signed [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                           phase_q, phase_d;

    logic                           accept;
    logic                           last_tap;
    logic                           mac_en, mac_load;
    logic signed [DATA_WIDTH-1:0]   mac_a, mac_b;
    logic signed [COEFFICIENTS_WIDTH-1:0] mac_c;
    logic signed [AccW-1:0]         mac_acc;
    logic signed [AccW-1:0]         acc_shift;
    logic signed [DATA_WIDTH-1:0]   sat_val;

    assign accept    = in_valid & in_ready;
    assign last_tap  = (tap_q == TapW'(Half - 1));
    assign out_valid = (state_q == StOutE) || (state_q == StOutO);
    assign data_out  = dout_q;
    assign out_phase = phase_q;

    // Fold symmetric taps onto the pre-adder; the odd centre tap has no partner.
    always_comb begin
        mac_a = '0;
        mac_b = '0;
        mac_c = '0;
        for (int t = 0; t < Half; t++) begin
            if (tap_q == TapW'(t)) begin
                if (state_q == StMacO) begin
                    if (t < Half - 1) begin
                        mac_a = x_q[t];
                        mac_b = x_q[D-2-t];
                        mac_c = COEFFICIENTS_WIDTH'(Coeffs[2*t+1]);
                    end else begin
                        mac_a = x_q[(D-2)/2];
                        mac_b = '0;
                        mac_c = COEFFICIENTS_WIDTH'(Coeffs[D-1]);
                    end
                end else begin
                    mac_a = x_q[t];
                    mac_b = x_q[D-1-t];
                    mac_c = COEFFICIENTS_WIDTH'(Coeffs[2*t]);
                end
            end
        end
    end

    fir_fold_mac #(
        .DataW  (DATA_WIDTH),
        .CoeffW (COEFFICIENTS_WIDTH),
        .AccW   (AccW)
    ) u_mac (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .a_i     (mac_a),
        .b_i     (mac_b),
        .coeff_i (mac_c),
        .load_i  (mac_load),
        .en_i    (mac_en),
        .acc_o   (mac_acc)
    );

    always_comb begin
        acc_shift = mac_acc >>> FracBits;
        if (acc_shift > SatMax) begin
            sat_val = DATA_WIDTH'(SatMax);
        end else if (acc_shift < SatMin) begin
            sat_val = DATA_WIDTH'(SatMin);
        end else begin
            sat_val = DATA_WIDTH'(acc_shift);
        end
    end

    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        dout_d   = dout_q;
        phase_d  = phase_q;
        in_ready = 1'b0;
        mac_en   = 1'b0;
        mac_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = StMacE;
                    tap_d   = '0;
                end
            end
            StMacE, StMacO: begin
                mac_en   = 1'b1;
                mac_load = (tap_q == '0);
                if (last_tap) begin
                    state_d = (state_q == StMacE) ? StOutE : StOutO;
                    tap_d   = '0;
                    dout_d  = sat_val;
                    phase_d = (state_q == StMacO);
                end else begin
                    tap_d = tap_q + TapW'(1);
                end
            end
            StOutE: begin
                if (out_ready) begin
                    state_d = StMacO;
                end
            end
            StOutO: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            tap_q   <= '0;
            dout_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            dout_q  <= dout_d;
            phase_q <= phase_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < D; i++) begin
                x_q[i] <= '0;
            end
        end else if (accept) begin
            x_q[0] <= data_in;
            for (int i = 1; i < D; i++) begin
                x_q[i] <= x_q[i-1];
            end
        end
    end

endmodule
